// File: rtl/dsh.sv
`default_nettype none
// ============================================================================
// Module   : dsh
// Purpose  : Buffered 3-to-8 one-hot decoder; each queued code is shown on
//            onehot for HOLD cycles, back-to-back with no gap.
// Revision : 1.0 - initial release
// ============================================================================
module dsh #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               code,
  input  logic                     code_vld,
  output logic                     code_rdy,
  output logic [7:0]               onehot,
  output logic                     out_vld,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_HW = $clog2(HOLD + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_mem [DEPTH];
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_CW-1:0]   r_count;
  logic [c_HW-1:0]   r_hcnt;
  logic [7:0]        r_onehot;
  logic              r_out_vld;

  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic [2:0]        w_head;

  assign code_rdy   = (r_count != c_CW'(DEPTH));
  assign w_push     = code_vld & code_rdy;
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rptr];
  // Pop decision uses registered count, so a fresh push is never popped the same cycle.
  assign w_pop      = w_nonempty & ((r_state == IDLE) | (r_hcnt == '0));

  assign onehot  = r_onehot;
  assign out_vld = r_out_vld;
  assign count   = r_count;
  assign busy    = r_out_vld | w_nonempty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_hcnt    <= '0;
      r_onehot  <= 8'h00;
      r_out_vld <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        IDLE: begin
          if (w_nonempty) begin
            r_onehot  <= 8'h01 << w_head;
            r_out_vld <= 1'b1;
            r_hcnt    <= c_HW'(HOLD - 1);
            r_state   <= SHOW;
          end
        end
        SHOW: begin
          if (r_hcnt != '0) begin
            r_hcnt <= r_hcnt - 1'b1;
          end else if (w_nonempty) begin
            r_onehot <= 8'h01 << w_head;
            r_hcnt   <= c_HW'(HOLD - 1);
          end else begin
            r_onehot  <= 8'h00;
            r_out_vld <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsh.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsh
// Purpose  : Self-checking bench for dsh (DEPTH=4, HOLD=3) with a prsh model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsh;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code;
  logic       code_vld;
  logic       code_rdy;
  logic [7:0] onehot;
  logic       out_vld;
  logic [2:0] count;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp_oh;
  } vec_t;

  vec_t tbl [8];

  dsh #(.DEPTH(4), .HOLD(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .code     (code),
    .code_vld (code_vld),
    .code_rdy (code_rdy),
    .onehot   (onehot),
    .out_vld  (out_vld),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural 8-to-3 priority encoder (highest set bit wins).
  function automatic logic [2:0] prsh(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  logic [7:0] exp_oh;

  initial begin
    tbl[0] = '{3'd0, 8'h01};
    tbl[1] = '{3'd1, 8'h02};
    tbl[2] = '{3'd2, 8'h04};
    tbl[3] = '{3'd3, 8'h08};
    tbl[4] = '{3'd4, 8'h10};
    tbl[5] = '{3'd5, 8'h20};
    tbl[6] = '{3'd6, 8'h40};
    tbl[7] = '{3'd7, 8'h80};

    // Reset held two cycles while a code is offered
    rst_n = 1'b0; code_vld = 1'b1; code = 3'd5;
    tick(); tick();
    chk("rst_onehot", onehot, 8'h00);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_code_rdy", code_rdy, 1);
    code_vld = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_count", count, 0);
      chk("post_rst_out_vld", out_vld, 0);
    end

    // Single codes 0..7 with round trip through prsh
    for (int v = 0; v < 8; v++) begin
      code = tbl[v].code; code_vld = 1'b1;
      tick();
      code_vld = 1'b0;
      chk("single_count", count, 1);
      chk("single_early_vld", out_vld, 0);
      for (int h = 0; h < 3; h++) begin
        tick();
        chk("single_onehot", onehot, tbl[v].exp_oh);
        chk("single_out_vld", out_vld, 1);
        chk("single_prsh", prsh(onehot), tbl[v].code);
      end
      tick();
      chk("single_end_onehot", onehot, 8'h00);
      chk("single_end_vld", out_vld, 0);
      chk("single_end_busy", busy, 0);
    end

    // Back-to-back 0 then 7
    code = 3'd0; code_vld = 1'b1;
    tick();
    chk("b2b_count0", count, 1);
    code = 3'd7;
    tick();
    code_vld = 1'b0;
    chk("b2b_count1", count, 1);
    chk("b2b_oh_a0", onehot, 8'h01);
    tick(); chk("b2b_oh_a1", onehot, 8'h01); chk("b2b_count2", count, 1);
    tick(); chk("b2b_oh_a2", onehot, 8'h01); chk("b2b_count3", count, 1);
    tick(); chk("b2b_oh_b0", onehot, 8'h80); chk("b2b_count4", count, 0);
    tick(); chk("b2b_oh_b1", onehot, 8'h80);
    tick(); chk("b2b_oh_b2", onehot, 8'h80);
    tick(); chk("b2b_end_oh", onehot, 8'h00); chk("b2b_end_vld", out_vld, 0);

    // Burst 1..7 with code_vld held: code 1 pops at once, so 1..6 fit and 7 meets a full FIFO
    for (int t = 0; t < 22; t++) begin
      code_vld = (t < 7);
      code = 3'(t + 1);
      tick();
      exp_oh = (t >= 1 && t <= 18) ? (8'h01 << ((t - 1) / 3 + 1)) : 8'h00;
      chk("full_onehot", onehot, exp_oh);
      chk("full_out_vld", out_vld, (exp_oh != 8'h00));
      chk("full_count_max", (count <= 3'd4), 1);
      if (t == 5 || t == 6) begin
        chk("full_count4", count, 4);
        chk("full_rdy_low", code_rdy, 0);
      end
    end
    code_vld = 1'b0;
    chk("full_end_busy", busy, 0);

    // Reset during the second cycle of code 2's display; 4 and 6 must be lost
    code_vld = 1'b1;
    code = 3'd2; tick();
    code = 3'd4; tick();
    chk("mid_oh_first", onehot, 8'h04);
    code = 3'd6; tick();
    code_vld = 1'b0;
    chk("mid_oh_second", onehot, 8'h04);
    chk("mid_count", count, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_oh", onehot, 8'h00);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_vld", out_vld, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_no_replay", out_vld, 0);
      chk("mid_no_replay_oh", onehot, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
